alu_seq: RTL
============

Name: alu_seq

Overview:
- Multi-byte operation sequencer that drives the 8-bit combinational ALU's command interface.
- Splits an NBYTES-wide add, left shift or right shift into per-byte ALU commands, one byte per clock.
- Chains the ALU's shift/carry out (sc_o) back into sc_i on the next byte, and assembles the wide result.
- Sits between the control unit and the ALU; the ALU instance lives outside this block, at the datapath top.

Parameters:
- NBYTES, 2, operand width in bytes (W = 8*NBYTES); legal range 1..8.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- op  input  2  00=ADD, 01=SHL, 10=SHR, 11=illegal
- opA  input  W  operand A, captured at start
- opB  input  W  operand B, captured at start; ignored for shifts
- alu_cmd  output  3  to ALU: 000 add, 001 left shift, 010 right shift
- inA  output  8  current byte of A to ALU
- inB  output  8  current byte of B to ALU (0 for shifts)
- sc_i  output  1  carry/shift-in to ALU
- rslt  input  8  ALU result byte
- sc_o  input  1  ALU carry/shift-out
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when result is valid
- result  output  W  assembled result, held until next accepted start
- carry_out  output  1  final sc_o of the chain, held with result

Behaviour:
- Reset (asynchronous): state=IDLE; busy=0, done=0, result=0, carry_out=0, internal carry=0; alu_cmd=000, inA=0, inB=0, sc_i=0.
- IDLE, start=1 at edge E:
  - Capture opA/opB/op.
  - Clear the carry register (or load the CIN_EN initial bit).
  - ADD/SHL: byte index = 0 (LSB first). SHR: byte index = NBYTES-1 (MSB first).
  - Go to RUN.
- op=11 at start: go directly to DONE; result=0, carry_out=0.
- RUN: drive inA/inB from the indexed byte, sc_i from the carry register, and alu_cmd from op; all combinational from registers. At each edge:
  - rslt is written into the indexed result byte.
  - The carry register takes sc_o.
  - The index steps toward the final byte (up for ADD/SHL, down for SHR).
  - After the final byte's edge, carry_out takes sc_o and state goes to DONE.
- Latency: the start edge plus NBYTES RUN edges; done is high during the cycle after edge E+NBYTES.
- DONE: done=1 for exactly one cycle, busy=0; the next edge returns to IDLE.
- The start input is ignored in RUN and DONE; there is no queueing, and a held start is accepted in the next IDLE.
- result is cleared at an accepted start. Intermediate bytes are visible during RUN; only the value at done is meaningful.
- SHL semantics (W-bit): result={A[W-2:0],cin}, carry_out=A[W-1].
- SHR semantics (W-bit): result={cin,A[W-1:1]}, carry_out=A[0].
- ADD semantics: {carry_out,result}=A+B+cin, computed in W+1 bits.
- cin is 0 unless ALU_SEQ_CIN_EN is defined.
- Reset mid-RUN aborts immediately and leaves all outputs at their reset values. No partial result is retained, and no done pulse is issued.
- Outside RUN, the ALU-facing outputs are held at 000/0/0/0.

Optional Feature:
- ALU_SEQ_CIN_EN defined:
  - Adds an input port cin (1 bit), sampled at start.
  - cin is loaded into the carry register: it is the add carry-in, the SHL fill bit into bit 0, or the SHR fill bit into bit W-1.
  - This enables chaining sequences wider than W.
- ALU_SEQ_CIN_EN undefined: no cin port; the initial carry is 0.

Decomposition:
- Shared package alu_pkg holds:
  - ALU command constants ALU_ADD=3'b000, ALU_SHL=3'b001, ALU_SHR=3'b010, shared with the ALU and the control unit.
  - The op encoding typedef seq_op_t (ADD/SHL/SHR/ILL).
  - The state typedef seq_state_t (IDLE, RUN, DONE).
- No sub-module: the byte counter and carry register are small and inline. The ALU is connected externally.

Test Plan (NBYTES=2, external ALU connected; without ALU_SEQ_CIN_EN unless stated):
- ADD A=0x00FF, B=0x0001 -> result=0x0100, carry_out=0; done high for exactly 1 cycle, in the cycle after edge E+2; busy high for 2 cycles.
- ADD A=0xFFFF, B=0x0001 -> result=0x0000, carry_out=1. With ALU_SEQ_CIN_EN and cin=1, A=0x0000, B=0x0000 -> result=0x0001.
- SHL A=0x8001 -> result=0x0002, carry_out=1. SHR A=0x0101 -> result=0x0080, carry_out=1; sc_i sequence is 0 then 1, high byte driven first.
- start re-pulsed during RUN with different operands -> ignored; the first result completes. op=11 -> done the cycle after start, result=0.
- reset asserted asynchronously mid-RUN (between the two byte edges) -> busy=0, result=0, carry_out=0 immediately, no done. A subsequent ADD 0x1234+0x1111 -> 0x2345.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module : alu_pkg
//  Brief  : ALU command codes, sequencer op encoding and sequencer states.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_SHR = 3'b010;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SHL = 2'b01,
    SHR = 2'b10,
    ILL = 2'b11
  } seq_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module : alu_seq
//  Brief  : Splits an NBYTES-wide add/shift into byte commands for the 8-bit
//           ALU. Optional macro ALU_SEQ_CIN_EN adds a carry/fill-in port cin.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [8*NBYTES-1:0] opA,
  input  logic [8*NBYTES-1:0] opB,
`ifdef ALU_SEQ_CIN_EN
  input  logic                cin,
`endif
  output logic [2:0]          alu_cmd,
  output logic [7:0]          inA,
  output logic [7:0]          inB,
  output logic                sc_i,
  input  logic [7:0]          rslt,
  input  logic                sc_o,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] c_last_idx = IDXW'(NBYTES - 1);

  seq_state_t      r_state;
  seq_state_t      w_next_state;
  seq_op_t         r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic [W-1:0]    r_result;
  logic            r_carry_out;
  logic            w_cin;
  logic            w_accept;
  logic            w_last;
  logic [7:0]      w_byte_a;
  logic [7:0]      w_byte_b;

`ifdef ALU_SEQ_CIN_EN
  assign w_cin = cin;
`else
  assign w_cin = 1'b0;
`endif

  assign w_accept  = (r_state == IDLE) && start;
  // SHR walks MSB to LSB, the others LSB to MSB
  assign w_last    = (r_op == SHR) ? (r_idx == '0) : (r_idx == c_last_idx);
  assign result    = r_result;
  assign carry_out = r_carry_out;

  always_comb begin
    w_byte_a = 8'h00;
    w_byte_b = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_byte_a = r_a[8*i +: 8];
        w_byte_b = r_b[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    alu_cmd      = ALU_ADD;
    inA          = 8'h00;
    inB          = 8'h00;
    sc_i         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = (seq_op_t'(op) == ILL) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        inA  = w_byte_a;
        inB  = (r_op == ADD) ? w_byte_b : 8'h00;
        sc_i = r_carry;
        case (r_op)
          SHL:     alu_cmd = ALU_SHL;
          SHR:     alu_cmd = ALU_SHR;
          default: alu_cmd = ALU_ADD;
        endcase
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else if (w_accept) begin
      r_op        <= seq_op_t'(op);
      r_a         <= opA;
      r_b         <= opB;
      r_carry     <= w_cin;
      r_idx       <= (seq_op_t'(op) == SHR) ? c_last_idx : '0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else if (r_state == RUN) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (r_idx == IDXW'(i)) begin
          r_result[8*i +: 8] <= rslt;
        end
      end
      r_carry <= sc_o;
      if (w_last) begin
        r_carry_out <= sc_o;
      end else begin
        r_idx <= (r_op == SHR) ? (r_idx - IDXW'(1)) : (r_idx + IDXW'(1));
      end
    end
  end

endmodule

`default_nettype wire
